serial_pattern_tx: RTL

Serial pattern transmitter that feeds single-bit stimulus into the sequence-detector FSM. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first as a qualified serial bit stream. A golden counter tracks overlapping occurrences of a 4-bit target pattern in the transmitted stream, so a bench can compare it directly against the detector's `dout` pulses.

---
 rtl/serial_pattern_tx.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts parallel words over valid/ready and shifts them out MSB-first,
// while counting overlapping occurrences of a 4-bit target pattern in the transmitted stream.
module serial_pattern_tx #(
  parameter int         WIDTH      = 8,
  parameter logic [3:0] PATTERN    = 4'b1011,
  parameter int         GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [15:0]      match_count,
  output logic [1:0]       state
);

  // state | meaning
  // IDLE  | waiting for a word, data_ready high
  // SHIFT | word bits on dout, one per cycle, MSB first
  // GAP   | idle spacing after a word, GAP_CYCLES long
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [3:0]       hist;
  logic [2:0]       fill_cnt;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    data_ready = 1'b0;
    dout       = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          load    = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        dout       = shreg[WIDTH-1];
        dout_valid = 1'b1;
        busy       = 1'b1;
        if (bit_cnt == '0) begin
          if (GAP_CYCLES > 0) state_d = S_GAP;
          else                state_d = S_IDLE;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      hist        <= '0;
      fill_cnt    <= '0;
      match_count <= '0;
    end else begin
      if (load) begin
        shreg   <= data_in;
        bit_cnt <= BIT_LOAD;
      end else if (state_q == S_SHIFT) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt - 1'b1;
        if (bit_cnt == '0) gap_cnt <= GAP_LOAD;
      end else if (state_q == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      // History spans word boundaries; the fill counter suppresses matches until 4 real bits exist.
      if (dout_valid) begin
        hist <= {hist[2:0], dout};
        if (fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;
        if (fill_cnt >= 3'd3 && {hist[2:0], dout} == PATTERN && match_count != 16'hFFFF)
          match_count <= match_count + 16'd1;
      end
    end
  end

  assign state = state_q;

endmodule
